// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared types, constants and lane helpers for the ROM loader packer
package rom_loader_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} load_state_t;

  localparam int BEAT_BYTES = 8;
  localparam int LANES = 4;
  localparam logic [24:0] CSUM_START_DEFAULT = 25'h200;

  function automatic logic [BEAT_BYTES*8-1:0] lane_place(input logic [15:0] word, input logic [1:0] lane);
    return {{(BEAT_BYTES*8-16){1'b0}}, word} << {lane, 4'b0000};
  endfunction

  function automatic logic [BEAT_BYTES-1:0] lane_be(input logic [1:0] lane);
    return {{(BEAT_BYTES-2){1'b0}}, 2'b11} << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/rom_loader_packer_if.sv
// rtl/rom_loader_packer_if.sv - ioctl download stream and toggle-handshake beat writer bundle
interface rom_loader_packer_if #(parameter int AW = 25);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_data;
  logic          ioctl_wait;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [7:0]    wr_be;
  logic          wr_req;
  logic          wr_ack;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, wr_ack,
    input  ioctl_wait, wr_addr, wr_data, wr_be, wr_req
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, wr_ack,
    output ioctl_wait, wr_addr, wr_data, wr_be, wr_req
  );
endinterface

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - wrap-around 16-bit header checksum, built only with LOADER_CHECKSUM_EN
`ifdef LOADER_CHECKSUM_EN
module loader_checksum #(
  parameter int            AW         = 25,
  parameter logic [AW-1:0] CSUM_START = AW'(25'h200)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   word,
  output logic [15:0]   sum
);

  logic hit;
  assign hit = en && (addr >= CSUM_START);

  // A word accepted on the same cycle as the clear is the first term of the new sum.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum <= 16'h0000;
    end else if (clear) begin
      sum <= hit ? word : 16'h0000;
    end else if (hit) begin
      sum <= sum + word;
    end
  end

endmodule
`endif

// File: rtl/rom_loader_packer.sv
// rtl/rom_loader_packer.sv - packs ioctl words into 64-bit toggle-handshake beats; LOADER_CHECKSUM_EN adds header checksum
module rom_loader_packer
  import rom_loader_pkg::*;
#(
  parameter int            AW         = 25,
  parameter logic [AW-1:0] CSUM_START = AW'(CSUM_START_DEFAULT)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  rom_loader_packer_if.slave   bus,
  output logic [AW-1:0]        rom_size,
  output logic                 load_done,
  output logic                 overrun,
  output logic [15:0]          checksum
);

  load_state_t state, state_n;

  logic                    dl_q, dl_rise, dl_fall, pending;
  logic [BEAT_BYTES*8-1:0] buf_data, buf_data_n, base_data, merged;
  logic [BEAT_BYTES-1:0]   buf_be, buf_be_n, base_be;
  logic [AW-4:0]           buf_beat, buf_beat_n;
  logic                    held_valid, held_valid_n;
  logic [15:0]             held_word, held_word_n;
  logic [AW-1:0]           held_addr, held_addr_n;
  logic                    flush_pend, flush_pend_n;
  logic [AW-1:0]           wr_addr_n, rom_size_n, base_size, word_end;
  logic [63:0]             wr_data_n;
  logic [7:0]              wr_be_n;
  logic                    wr_req_n, ioctl_wait_n, overrun_n;
  logic                    csum_clear, accept;
  logic                    iss;
  logic [63:0]             iss_data;
  logic [7:0]              iss_be;
  logic [AW-4:0]           iss_beat;
  logic [15:0]             word_swap;
  logic [1:0]              word_lane;
  logic [AW-4:0]           word_beat;

  assign dl_rise   = bus.ioctl_download && !dl_q;
  assign dl_fall   = !bus.ioctl_download && dl_q;
  assign pending   = bus.wr_req != bus.wr_ack;
  assign word_swap = {bus.ioctl_data[7:0], bus.ioctl_data[15:8]};
  assign word_lane = bus.ioctl_addr[2:1];
  assign word_beat = bus.ioctl_addr[AW-1:3];
  assign word_end  = bus.ioctl_addr + AW'(2);
  assign load_done = (state == DONE);

  always_comb begin
    state_n      = state;
    csum_clear   = 1'b0;
    accept       = 1'b0;
    base_data    = buf_data;
    base_be      = buf_be;
    base_size    = rom_size;
    merged       = '0;
    buf_data_n   = buf_data;
    buf_be_n     = buf_be;
    buf_beat_n   = buf_beat;
    held_valid_n = held_valid;
    held_word_n  = held_word;
    held_addr_n  = held_addr;
    flush_pend_n = flush_pend;
    wr_addr_n    = bus.wr_addr;
    wr_data_n    = bus.wr_data;
    wr_be_n      = bus.wr_be;
    wr_req_n     = bus.wr_req;
    ioctl_wait_n = bus.ioctl_wait;
    rom_size_n   = rom_size;
    overrun_n    = overrun;
    iss          = 1'b0;
    iss_data     = '0;
    iss_be       = '0;
    iss_beat     = '0;

    // The rising edge clears everything first, so a coincident word lands in an empty beat.
    if (dl_rise) begin
      csum_clear   = 1'b1;
      base_data    = '0;
      base_be      = '0;
      base_size    = '0;
      buf_data_n   = '0;
      buf_be_n     = '0;
      held_valid_n = 1'b0;
      flush_pend_n = 1'b0;
      rom_size_n   = '0;
      overrun_n    = 1'b0;
      ioctl_wait_n = 1'b0;
      state_n      = FILL;
      accept       = bus.ioctl_wr;
    end else if (bus.ioctl_wr && bus.ioctl_wait) begin
      overrun_n = 1'b1;
    end else if (state == FILL && bus.ioctl_wr && bus.ioctl_download) begin
      accept = 1'b1;
    end

    if (accept) begin
      rom_size_n = (word_end > base_size) ? word_end : base_size;
      if (base_be != '0 && word_beat != buf_beat) begin
        iss          = 1'b1;
        iss_data     = base_data;
        iss_be       = base_be;
        iss_beat     = buf_beat;
        held_valid_n = 1'b1;
        held_word_n  = word_swap;
        held_addr_n  = bus.ioctl_addr;
        state_n      = WAIT;
      end else begin
        merged = (base_data & ~lane_place(16'hFFFF, word_lane)) | lane_place(word_swap, word_lane);
        if (word_lane == 2'd3) begin
          iss      = 1'b1;
          iss_data = merged;
          iss_be   = base_be | lane_be(word_lane);
          iss_beat = word_beat;
          state_n  = WAIT;
        end else begin
          buf_data_n = merged;
          buf_be_n   = base_be | lane_be(word_lane);
          buf_beat_n = word_beat;
        end
      end
    end

    if (!dl_rise) begin
      case (state)
        FILL: begin
          if (dl_fall) begin
            if (buf_be != '0) begin
              iss          = 1'b1;
              iss_data     = buf_data;
              iss_be       = buf_be;
              iss_beat     = buf_beat;
              flush_pend_n = 1'b1;
              state_n      = WAIT;
            end else begin
              state_n = DONE;
            end
          end
        end
        WAIT: begin
          if (dl_fall) flush_pend_n = 1'b1;
          if (!pending) begin
            if (flush_pend || dl_fall) begin
              // After an issue the buffer is empty, so only a held word can remain to flush.
              if (held_valid) begin
                iss          = 1'b1;
                iss_data     = lane_place(held_word, held_addr[2:1]);
                iss_be       = lane_be(held_addr[2:1]);
                iss_beat     = held_addr[AW-1:3];
                held_valid_n = 1'b0;
              end else begin
                ioctl_wait_n = 1'b0;
                flush_pend_n = 1'b0;
                state_n      = DONE;
              end
            end else begin
              ioctl_wait_n = 1'b0;
              state_n      = FILL;
              if (held_valid) begin
                buf_data_n   = lane_place(held_word, held_addr[2:1]);
                buf_be_n     = lane_be(held_addr[2:1]);
                buf_beat_n   = held_addr[AW-1:3];
                held_valid_n = 1'b0;
              end
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end

    if (iss) begin
      wr_addr_n    = {iss_beat, 3'b000};
      wr_data_n    = iss_data;
      wr_be_n      = iss_be;
      wr_req_n     = !bus.wr_req;
      ioctl_wait_n = 1'b1;
      if (!(state == WAIT && held_valid)) begin
        buf_data_n = '0;
        buf_be_n   = '0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      dl_q           <= 1'b0;
      buf_data       <= '0;
      buf_be         <= '0;
      buf_beat       <= '0;
      held_valid     <= 1'b0;
      held_word      <= '0;
      held_addr      <= '0;
      flush_pend     <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.wr_be      <= '0;
      bus.wr_req     <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      rom_size       <= '0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_n;
      dl_q           <= bus.ioctl_download;
      buf_data       <= buf_data_n;
      buf_be         <= buf_be_n;
      buf_beat       <= buf_beat_n;
      held_valid     <= held_valid_n;
      held_word      <= held_word_n;
      held_addr      <= held_addr_n;
      flush_pend     <= flush_pend_n;
      bus.wr_addr    <= wr_addr_n;
      bus.wr_data    <= wr_data_n;
      bus.wr_be      <= wr_be_n;
      bus.wr_req     <= wr_req_n;
      bus.ioctl_wait <= ioctl_wait_n;
      rom_size       <= rom_size_n;
      overrun        <= overrun_n;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  loader_checksum #(.AW(AW), .CSUM_START(CSUM_START)) u_checksum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (csum_clear),
    .en      (accept),
    .addr    (bus.ioctl_addr),
    .word    (word_swap),
    .sum     (checksum)
  );
`else
  logic unused_csum;
  assign unused_csum = ^{csum_clear, CSUM_START};
  assign checksum    = 16'h0000;
`endif

  logic unused_addr0;
  assign unused_addr0 = bus.ioctl_addr[0];

endmodule

// File: tb/tb_rom_loader_packer.sv
// tb/tb_rom_loader_packer.sv - directed self-checking bench for rom_loader_packer
module tb_rom_loader_packer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] rom_size;
  logic        load_done, overrun;
  logic [15:0] checksum;

  rom_loader_packer_if #(.AW(25)) bus();

  rom_loader_packer #(.AW(25)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus.slave),
    .rom_size  (rom_size),
    .load_done (load_done),
    .overrun   (overrun),
    .checksum  (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wait_rise_cyc = 0;
  int wait_fall_cyc = 0;
  logic prev_wait = 1'b0;
  logic [24:0] q_addr[$];
  logic [63:0] q_data[$];
  logic [7:0]  q_be[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Downstream writer model: logs each beat, acks after ack_delay cycles.
  initial begin
    bus.wr_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        bus.wr_ack = 1'b0;
        ack_cnt = 0;
      end else if (bus.wr_req != bus.wr_ack) begin
        if (ack_cnt == 0) begin
          q_addr.push_back(bus.wr_addr);
          q_data.push_back(bus.wr_data);
          q_be.push_back(bus.wr_be);
        end
        if (ack_cnt >= ack_delay) begin
          bus.wr_ack = bus.wr_req;
          ack_cnt = 0;
          ack_cyc = cyc;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.ioctl_wait && !prev_wait) wait_rise_cyc = cyc;
      if (!bus.ioctl_wait && prev_wait) wait_fall_cyc = cyc;
      prev_wait = bus.ioctl_wait;
    end
  end

  task automatic send(input logic [24:0] a, input logic [15:0] d);
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", 64'd1, 64'd0);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    q_addr.delete();
    q_data.delete();
    q_be.delete();
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_load(input int exp_done);
    int n = 0;
    bus.ioctl_download = 1'b0;
    while (done_cnt < exp_done && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) check_eq("done_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_data = '0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_wait", 64'(bus.ioctl_wait), 64'd0);
    check_eq("rst_req", 64'(bus.wr_req), 64'd0);
    check_eq("rst_addr", 64'(bus.wr_addr), 64'd0);
    check_eq("rst_data", bus.wr_data, 64'd0);
    check_eq("rst_be", 64'(bus.wr_be), 64'd0);
    check_eq("rst_size", 64'(rom_size), 64'd0);
    check_eq("rst_done", 64'(load_done), 64'd0);
    check_eq("rst_ovr", 64'(overrun), 64'd0);
    check_eq("rst_csum", 64'(checksum), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Sequential load of two full beats
    ack_delay = 0;
    start_load();
    for (int i = 0; i < 8; i++) send(25'(2 * i), {8'(2 * i + 2), 8'(2 * i + 1)});
    end_load(1);
    check_eq("seq_nbeats", 64'(q_addr.size()), 64'd2);
    check_eq("seq_addr0", 64'(q_addr[0]), 64'd0);
    check_eq("seq_lane0", 64'(q_data[0][15:0]), 64'h0102);
    check_eq("seq_data0", q_data[0], 64'h0708_0506_0304_0102);
    check_eq("seq_be0", 64'(q_be[0]), 64'hFF);
    check_eq("seq_addr1", 64'(q_addr[1]), 64'd8);
    check_eq("seq_data1", q_data[1], 64'h0F10_0D0E_0B0C_090A);
    check_eq("seq_be1", 64'(q_be[1]), 64'hFF);
    check_eq("seq_size", 64'(rom_size), 64'd16);
    check_eq("seq_done", 64'(done_cnt), 64'd1);

    // Partial tail flushed by the falling edge
    start_load();
    for (int i = 0; i < 5; i++) send(25'(2 * i), {8'(2 * i + 2), 8'(2 * i + 1)});
    end_load(2);
    check_eq("tail_nbeats", 64'(q_addr.size()), 64'd2);
    check_eq("tail_addr1", 64'(q_addr[1]), 64'd8);
    check_eq("tail_be1", 64'(q_be[1]), 64'h03);
    check_eq("tail_data1", q_data[1], 64'h0000_0000_0000_090A);
    check_eq("tail_done_lat", 64'(done_cyc), 64'(ack_cyc + 1));
    check_eq("tail_size", 64'(rom_size), 64'd10);

    // Address jump forces an early beat and a held word
    start_load();
    send(25'h0, 16'h1111);
    send(25'h2, 16'h2222);
    send(25'h40, 16'h3412);
    end_load(3);
    check_eq("jump_nbeats", 64'(q_addr.size()), 64'd2);
    check_eq("jump_addr0", 64'(q_addr[0]), 64'd0);
    check_eq("jump_be0", 64'(q_be[0]), 64'h0F);
    check_eq("jump_data0", q_data[0], 64'h0000_0000_2222_1111);
    check_eq("jump_addr1", 64'(q_addr[1]), 64'h40);
    check_eq("jump_be1", 64'(q_be[1]), 64'h03);
    check_eq("jump_data1", q_data[1], 64'h0000_0000_0000_1234);
    check_eq("jump_size", 64'(rom_size), 64'h42);

    // Stall with a dropped word during ioctl_wait
    ack_delay = 20;
    start_load();
    for (int i = 0; i < 4; i++) send(25'(2 * i), {8'(2 * i + 2), 8'(2 * i + 1)});
    repeat (3) @(negedge clk_sys);
    check_eq("stall_wait_hi", 64'(bus.ioctl_wait), 64'd1);
    bus.ioctl_addr = 25'h8;
    bus.ioctl_data = 16'hDEAD;
    bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    check_eq("stall_ovr", 64'(overrun), 64'd1);
    send(25'hA, 16'h0B0A);
    check_eq("stall_len", 64'(wait_fall_cyc - wait_rise_cyc), 64'd21);
    check_eq("stall_release", 64'(wait_fall_cyc), 64'(ack_cyc + 1));
    end_load(4);
    check_eq("stall_nbeats", 64'(q_addr.size()), 64'd2);
    check_eq("stall_addr1", 64'(q_addr[1]), 64'd8);
    check_eq("stall_be1", 64'(q_be[1]), 64'h0C);
    check_eq("stall_data1", q_data[1], 64'h0000_0000_0A0B_0000);
    check_eq("stall_size", 64'(rom_size), 64'd12);
    check_eq("stall_ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of an outstanding write
    ack_delay = 50;
    start_load();
    for (int i = 0; i < 4; i++) send(25'(2 * i), 16'h5555);
    repeat (4) @(negedge clk_sys);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_eq("mid_rst_wait", 64'(bus.ioctl_wait), 64'd0);
    check_eq("mid_rst_req", 64'(bus.wr_req), 64'd0);
    check_eq("mid_rst_data", bus.wr_data, 64'd0);
    check_eq("mid_rst_be", 64'(bus.wr_be), 64'd0);
    check_eq("mid_rst_size", 64'(rom_size), 64'd0);
    check_eq("mid_rst_ovr", 64'(overrun), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    ack_delay = 0;
    start_load();
    for (int i = 0; i < 4; i++) send(25'(2 * i), 16'h0201);
    check_eq("new_req", 64'(bus.wr_req), 64'd1);
    end_load(5);
    check_eq("new_nbeats", 64'(q_addr.size()), 64'd1);
    check_eq("new_data0", q_data[0], 64'h0102_0102_0102_0102);

    // Header checksum region
    start_load();
    send(25'h1FE, 16'h0100);
    send(25'h200, 16'h3412);
    send(25'h202, 16'hFFFF);
    end_load(6);
    check_eq("csum_addr0", 64'(q_addr[0]), 64'h1F8);
    check_eq("csum_be0", 64'(q_be[0]), 64'hC0);
    check_eq("csum_data1", q_data[1], 64'h0000_0000_FFFF_1234);
    check_eq("csum_size", 64'(rom_size), 64'h204);
`ifdef LOADER_CHECKSUM_EN
    check_eq("csum_value", 64'(checksum), 64'h1233);
`else
    check_eq("csum_value", 64'(checksum), 64'h0000);
`endif
    check_eq("total_done", 64'(done_cnt), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
